sync_down_counter_gl: RTL and testbench



---
 rtl/sync_down_counter_gl_if.sv | 7 +
 rtl/sync_down_counter_gl.sv | 49 ++++
 tb/tb_sync_down_counter_gl.sv | 87 ++++++++
 3 files changed

// File: rtl/sync_down_counter_gl_if.sv
// Count bus of the gate-level down counter: the counter drives it, observers read it.
interface sync_down_counter_gl_if;
    logic [3:0] out;

    modport master (output out);
    modport slave  (input  out);
endinterface

// File: rtl/sync_down_counter_gl.sv
// Free-running 4-bit down counter built from gate primitives and four D flip-flops.
// Wraps from 0 to 15 through the borrow chain alone; rst clears it asynchronously.
module sync_down_counter_gl_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= 1'b0;
        else
            q <= d;
    end
endmodule

module sync_down_counter_gl (
    input  logic                          clk,
    input  logic                          rst,
    sync_down_counter_gl_if.master        bus
);
    wire [3:0] q;
    wire [3:0] d;
    wire       nq0;
    wire       nq1;
    wire       nq2;
    wire       borrow2;
    wire       borrow3;

    not g_nq0 (nq0, q[0]);
    not g_nq1 (nq1, q[1]);
    not g_nq2 (nq2, q[2]);

    // Bit i toggles when every lower bit is 0, i.e. a borrow ripples up to it.
    and g_b2 (borrow2, nq0, nq1);
    and g_b3 (borrow3, nq0, nq1, nq2);

    not g_d0 (d[0], q[0]);
    xor g_d1 (d[1], q[1], nq0);
    xor g_d2 (d[2], q[2], borrow2);
    xor g_d3 (d[3], q[3], borrow3);

    sync_down_counter_gl_dff u_ff0 (.clk(clk), .rst(rst), .d(d[0]), .q(q[0]));
    sync_down_counter_gl_dff u_ff1 (.clk(clk), .rst(rst), .d(d[1]), .q(q[1]));
    sync_down_counter_gl_dff u_ff2 (.clk(clk), .rst(rst), .d(d[2]), .q(q[2]));
    sync_down_counter_gl_dff u_ff3 (.clk(clk), .rst(rst), .d(d[3]), .q(q[3]));

    assign bus.out = q;
endmodule

// File: tb/tb_sync_down_counter_gl.sv
// Directed bench for sync_down_counter_gl: table of per-edge vectors plus
// hand-written sequences for power-up and mid-count asynchronous reset.
module tb_sync_down_counter_gl;
    typedef struct {
        logic       rst;
        logic [3:0] expected;
    } vector_t;

    logic clk = 1'b0;
    logic rst;
    int   applied     = 0;
    int   miscompares = 0;

    sync_down_counter_gl_if bus ();

    sync_down_counter_gl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One entry per rising edge: two edges held in reset, then two full periods and the wrap.
    vector_t vecs [35] = '{
        '{1'b0, 4'h0}, '{1'b0, 4'h0},
        '{1'b1, 4'hF}, '{1'b1, 4'hE}, '{1'b1, 4'hD}, '{1'b1, 4'hC},
        '{1'b1, 4'hB}, '{1'b1, 4'hA}, '{1'b1, 4'h9}, '{1'b1, 4'h8},
        '{1'b1, 4'h7}, '{1'b1, 4'h6}, '{1'b1, 4'h5}, '{1'b1, 4'h4},
        '{1'b1, 4'h3}, '{1'b1, 4'h2}, '{1'b1, 4'h1}, '{1'b1, 4'h0},
        '{1'b1, 4'hF}, '{1'b1, 4'hE}, '{1'b1, 4'hD}, '{1'b1, 4'hC},
        '{1'b1, 4'hB}, '{1'b1, 4'hA}, '{1'b1, 4'h9}, '{1'b1, 4'h8},
        '{1'b1, 4'h7}, '{1'b1, 4'h6}, '{1'b1, 4'h5}, '{1'b1, 4'h4},
        '{1'b1, 4'h3}, '{1'b1, 4'h2}, '{1'b1, 4'h1}, '{1'b1, 4'h0},
        '{1'b1, 4'hF}
    };

    task automatic applyStimulus(input logic rst_val);
        @(negedge clk);
        rst = rst_val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expected);
        applied++;
        if (bus.out !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: out=%b expected=%b at %0t", name, bus.out, expected, $time);
        end
    endtask

    initial begin
        rst = 1'b0;
        #1;
        checkOutput("power_up_clear", 4'h0);

        for (int i = 0; i < 35; i++) begin
            applyStimulus(vecs[i].rst);
            checkOutput($sformatf("vec%0d", i), vecs[i].expected);
        end

        // Count down from 1111 to 1010, then clear midway between edges.
        applyStimulus(1'b1); checkOutput("run_e", 4'hE);
        applyStimulus(1'b1); checkOutput("run_d", 4'hD);
        applyStimulus(1'b1); checkOutput("run_c", 4'hC);
        applyStimulus(1'b1); checkOutput("run_b", 4'hB);
        applyStimulus(1'b1); checkOutput("run_a", 4'hA);
        #4;
        rst = 1'b0;
        #1;
        checkOutput("async_clear_mid", 4'h0);
        @(posedge clk);
        #1;
        checkOutput("hold_edge1", 4'h0);
        @(posedge clk);
        #1;
        checkOutput("hold_edge2", 4'h0);
        applyStimulus(1'b1);
        checkOutput("restart_f", 4'hF);
        applyStimulus(1'b1);
        checkOutput("restart_e", 4'hE);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
